fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
// Fetch stage feeding the fetch/decode boundary: owns the PC and issues one
// instruction-memory request at a time over a valid/ready request channel.
// Presents {inst_f, PC_f, valid_f} to the decode side and holds them while decode stalls.
// Handles redirects from branch/jump resolution and drops stale responses.
// Contains a one-entry skid buffer so that no response is ever lost while stalled.
// PARAMETERS
// RESET_PC   32'h0100_0000  PC fetched first after reset
// NOP_INST   32'h0000_0013  inst_f value while empty/after reset (addi x0,x0,0)
// PORTS
// clk             in   1   rising-edge clock
// rst_n           in   1   asynchronous, active-low reset
// imem_req_valid  out  1   fetch request valid
// imem_req_ready  in   1   imem accepts request this cycle
// imem_addr       out  32  request address (current PC)
// imem_rsp_valid  in   1   response valid (no backpressure, >=1 cycle after accept)
// imem_rsp_data   in   32  fetched instruction
// redirect_valid  in   1   redirect the PC (branch/jump taken)
// redirect_pc     in   32  redirect target; bits [1:0] ignored, forced 0
// stall_d         in   1   decode cannot take inst_f this cycle
// PC_f            out  32  PC of inst_f
// inst_f          out  32  instruction to decode
// valid_f         out  1   inst_f/PC_f hold a live instruction
// BEHAVIOUR
// - Reset (async, rst_n=0): pc=RESET_PC, state=REQ, valid_f=0, skid empty,
//   PC_f=RESET_PC, inst_f=NOP_INST, imem_req_valid=0 while rst_n=0.
// - Handshake: request accepted when imem_req_valid & imem_req_ready at posedge;
//   at most one request outstanding. imem_addr=pc, stable while valid & !ready.
// - Consume: output slot drained at posedge when valid_f & !stall_d.
// - States: REQ, WAIT, DRAIN.
//   REQ:   imem_req_valid = !skid_valid. On accept -> WAIT, pc_inflight=pc.
//          imem_rsp_valid in REQ is ignored (late response from before reset).
//   WAIT:  on imem_rsp_valid -> REQ, pc <= pc_inflight+4 (32-bit wrap).
//          Response placement: slot empty or consumed this cycle -> output slot;
//          else -> skid. Skid full & slot full cannot occur (REQ blocked).
//   DRAIN: next imem_rsp_valid discarded -> REQ. No request issued in DRAIN.
// - Output slot refill on consume: skid entry first (skid moves to slot and
//   empties); else same-cycle response; else valid_f <= 0, inst_f <= NOP_INST.
// - Ordering: skid always older than any same-cycle response; program order kept.
// - Redirect (priority over all else), at posedge with redirect_valid=1:
//   pc <= {redirect_pc[31:2],2'b00}; valid_f <= 0; skid cleared.
//   In REQ, no accept -> stays REQ. In REQ with same-cycle accept -> DRAIN.
//   In WAIT without rsp -> DRAIN. In WAIT with same-cycle rsp -> rsp dropped, REQ.
//   In DRAIN -> stays DRAIN (one response still pending), pc updated.
//   Redirect with same-cycle consume: consume occurs, slot still cleared.
// - Latency: accept at cycle N, rsp at N+L -> valid_f=1 at N+L+1 (unstalled);
//   next request may be issued from cycle N+L+1.
// - Reset mid-operation: all state cleared immediately; any in-flight response
//   after rst_n rises arrives in REQ and is ignored.
// TESTING
// 1 Reset release, ready=1, L=1 -> addrs 0x0100_0000,_0004,_0008; PC_f/inst_f
//   follow in order, valid_f first high 2 cycles after first accept.
// 2 stall_d=1 for 4 cycles, ready=1 -> one rsp to slot, one to skid, then
//   imem_req_valid=0; on release skid drains, no loss/duplication of PCs.
// 3 Redirect to 0x0100_0102 during WAIT -> next rsp dropped, next request
//   addr 0x0100_0100, next valid_f with PC_f=0x0100_0100.
// 4 Redirect in same cycle as imem_rsp_valid -> response dropped, no DRAIN,
//   request to target issued next cycle.
// 5 Redirect to 0xFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0000_0000.
// 6 rst_n=0 during WAIT, rsp arrives after release -> valid_f stays 0 for it,
//   inst_f=0x0000_0013, first request addr 0x0100_0000.

Source files
------------

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues one instruction-memory request at a time and
// feeds {inst_f, PC_f, valid_f} to decode through an output slot backed by a one-entry skid.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0100_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        stall_d,
   output logic [31:0] PC_f,
   output logic [31:0] inst_f,
   output logic        valid_f,
   output logic [1:0]  o_dbg_state
);

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_WAIT  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_pc_inflight;
   logic        r_skid_valid;
   logic [31:0] r_skid_pc;
   logic [31:0] r_skid_inst;
   logic [31:0] r_pc_f;
   logic [31:0] r_inst_f;
   logic        r_valid_f;

   logic        w_accept;
   logic        w_consume;
   logic        w_rsp_live;
   logic        w_slot_free;
   logic [31:0] w_redirect_tgt;
   logic        w_unused_bits;

   // Handshake: a request transfers on a rising edge where imem_req_valid and
   // imem_req_ready are both high; while valid waits for ready, imem_addr holds.
   // Responses have no backpressure and only the one in WAIT is kept.
   assign imem_req_valid = rst_n & (r_state == S_REQ) & ~r_skid_valid;
   assign imem_addr      = r_pc;
   assign w_accept       = imem_req_valid & imem_req_ready;
   assign w_consume      = r_valid_f & ~stall_d;
   assign w_rsp_live     = (r_state == S_WAIT) & imem_rsp_valid;
   assign w_slot_free    = ~r_valid_f | w_consume;
   assign w_redirect_tgt = {redirect_pc[31:2], 2'b00};
   assign w_unused_bits  = ^redirect_pc[1:0];

   assign PC_f        = r_pc_f;
   assign inst_f      = r_inst_f;
   assign valid_f     = r_valid_f;
   assign o_dbg_state = r_state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_REQ;
         r_pc          <= RESET_PC;
         r_pc_inflight <= RESET_PC;
         r_skid_valid  <= 1'b0;
         r_skid_pc     <= RESET_PC;
         r_skid_inst   <= NOP_INST;
         r_pc_f        <= RESET_PC;
         r_inst_f      <= NOP_INST;
         r_valid_f     <= 1'b0;
      end else if (redirect_valid) begin
         r_pc         <= w_redirect_tgt;
         r_valid_f    <= 1'b0;
         r_inst_f     <= NOP_INST;
         r_skid_valid <= 1'b0;
         // Any request already accepted for the old path must be swallowed.
         case (r_state)
            S_REQ:   r_state <= w_accept ? S_DRAIN : S_REQ;
            S_WAIT:  r_state <= imem_rsp_valid ? S_REQ : S_DRAIN;
            S_DRAIN: r_state <= imem_rsp_valid ? S_REQ : S_DRAIN;
            default: r_state <= S_REQ;
         endcase
      end else begin
         case (r_state)
            S_REQ: begin
               if (w_accept) begin
                  r_state       <= S_WAIT;
                  r_pc_inflight <= r_pc;
               end
            end
            S_WAIT: begin
               if (imem_rsp_valid) begin
                  r_state <= S_REQ;
                  r_pc    <= r_pc_inflight + 32'd4;
               end
            end
            S_DRAIN: begin
               if (imem_rsp_valid) r_state <= S_REQ;
            end
            default: r_state <= S_REQ;
         endcase

         // The skid entry is always older than a same-cycle response.
         if (w_slot_free) begin
            if (r_skid_valid) begin
               r_pc_f    <= r_skid_pc;
               r_inst_f  <= r_skid_inst;
               r_valid_f <= 1'b1;
               if (w_rsp_live) begin
                  r_skid_pc   <= r_pc_inflight;
                  r_skid_inst <= imem_rsp_data;
               end else begin
                  r_skid_valid <= 1'b0;
               end
            end else if (w_rsp_live) begin
               r_pc_f    <= r_pc_inflight;
               r_inst_f  <= imem_rsp_data;
               r_valid_f <= 1'b1;
            end else if (w_consume) begin
               r_valid_f <= 1'b0;
               r_inst_f  <= NOP_INST;
            end
         end else if (w_rsp_live) begin
            r_skid_valid <= 1'b1;
            r_skid_pc    <= r_pc_inflight;
            r_skid_inst  <= imem_rsp_data;
         end
      end
   end

endmodule
